// File: rtl/ifid_branch_resolve.sv
// rtl/ifid_branch_resolve.sv - IF/ID pipeline register with decode-stage branch resolution
module ifid_branch_resolve #(
    parameter logic [31:0] NOP_WORD = 32'h00000000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instructionoutput,
    input  logic [31:0]      PCPLUS4,
    input  logic             stall,
    input  logic [31:0]      rs_data,
    input  logic [31:0]      rt_data,
    output logic [4:0]       rs_addr,
    output logic [4:0]       rt_addr,
    output logic [31:0]      id_instr,
    output logic [31:0]      id_pcplus4,
    output logic             id_valid,
    output logic [31:0]      BranchAdd,
    output logic             PCSrc,
    output logic [CNT_W-1:0] branch_count
);

    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic {
        EMPTY = 1'b0,
        VALID = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      id_instr_q, id_instr_d;
    logic [31:0]      id_pcplus4_q, id_pcplus4_d;
    logic [CNT_W-1:0] branch_count_q, branch_count_d;

    logic [5:0]  op;
    logic [15:0] imm;
    logic        taken;
    logic        redirect;
    logic [31:0] target;

    // State register: reset wins over every other update in the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= EMPTY;
            id_instr_q     <= NOP_WORD;
            id_pcplus4_q   <= 32'h0;
            branch_count_q <= '0;
        end else begin
            state_q        <= state_d;
            id_instr_q     <= id_instr_d;
            id_pcplus4_q   <= id_pcplus4_d;
            branch_count_q <= branch_count_d;
        end
    end

    // Next state: a redirect empties ID (wrong-path squash), otherwise any unstalled cycle loads
    always_comb begin
        state_d = state_q;
        if (redirect) begin
            state_d = EMPTY;
        end else if (!stall) begin
            state_d = VALID;
        end
    end

    // IF/ID payload and saturating redirect counter; flush beats stall beats load
    always_comb begin
        id_instr_d     = id_instr_q;
        id_pcplus4_d   = id_pcplus4_q;
        branch_count_d = branch_count_q;
        if (redirect) begin
            id_instr_d   = NOP_WORD;
            id_pcplus4_d = 32'h0;
            if (branch_count_q != CNT_MAX) begin
                branch_count_d = branch_count_q + CNT_ONE;
            end
        end else if (!stall) begin
            id_instr_d   = instructionoutput;
            id_pcplus4_d = PCPLUS4;
        end
    end

    // Decode and target generation; redirect is gated by a real instruction and no stall
    always_comb begin
        op     = id_instr_q[31:26];
        imm    = id_instr_q[15:0];
        taken  = 1'b0;
        target = id_pcplus4_q;
        case (op)
            OP_BEQ: begin
                taken  = (rs_data == rt_data);
                target = id_pcplus4_q + {{14{imm[15]}}, imm, 2'b00};
            end
            OP_BNE: begin
                taken  = (rs_data != rt_data);
                target = id_pcplus4_q + {{14{imm[15]}}, imm, 2'b00};
            end
            OP_J: begin
                taken  = 1'b1;
                target = {id_pcplus4_q[31:28], id_instr_q[25:0], 2'b00};
            end
            default: begin
                taken  = 1'b0;
                target = id_pcplus4_q;
            end
        endcase
        redirect = taken & (state_q == VALID) & ~stall;
    end

    assign rs_addr      = id_instr_q[25:21];
    assign rt_addr      = id_instr_q[20:16];
    assign id_instr     = id_instr_q;
    assign id_pcplus4   = id_pcplus4_q;
    assign id_valid     = (state_q == VALID);
    assign BranchAdd    = target;
    assign PCSrc        = redirect;
    assign branch_count = branch_count_q;

endmodule

// File: tb/tb_ifid_branch_resolve.sv
// tb/tb_ifid_branch_resolve.sv - vector/scoreboard bench for ifid_branch_resolve
module tb_ifid_branch_resolve;

    localparam logic [31:0] R_ADD = 32'h00000020;
    localparam logic [31:0] R_ALT = 32'h00000021;
    localparam logic [31:0] BEQ   = 32'h10220003;
    localparam logic [31:0] BNE   = 32'h1422FFFE;
    localparam logic [31:0] JMP   = 32'h08000010;

    typedef struct {
        logic        rst;
        logic        stl;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        chk;
        logic [31:0] e_instr;
        logic        e_valid;
        logic        e_pcsrc;
        logic [31:0] e_badd;
        logic [31:0] e_pc4;
        logic [15:0] e_cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instructionoutput = 32'h0;
    logic [31:0] PCPLUS4 = 32'h0;
    logic        stall = 1'b0;
    logic [31:0] rs_data = 32'h0;
    logic [31:0] rt_data = 32'h0;

    logic [4:0]  rs_addr, rt_addr, rs_addr2, rt_addr2;
    logic [31:0] id_instr, id_pcplus4, BranchAdd, id_instr2, id_pcplus42, BranchAdd2;
    logic        id_valid, PCSrc, id_valid2, PCSrc2;
    logic [15:0] branch_count;
    logic [1:0]  branch_count2;

    int errors = 0;
    int checks = 0;

    vec_t vecs[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    ifid_branch_resolve dut (
        .clk(clk), .reset(reset), .instructionoutput(instructionoutput), .PCPLUS4(PCPLUS4),
        .stall(stall), .rs_data(rs_data), .rt_data(rt_data), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .id_instr(id_instr), .id_pcplus4(id_pcplus4), .id_valid(id_valid), .BranchAdd(BranchAdd),
        .PCSrc(PCSrc), .branch_count(branch_count)
    );

    ifid_branch_resolve #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .instructionoutput(instructionoutput), .PCPLUS4(PCPLUS4),
        .stall(stall), .rs_data(rs_data), .rt_data(rt_data), .rs_addr(rs_addr2), .rt_addr(rt_addr2),
        .id_instr(id_instr2), .id_pcplus4(id_pcplus42), .id_valid(id_valid2), .BranchAdd(BranchAdd2),
        .PCSrc(PCSrc2), .branch_count(branch_count2)
    );

    function automatic vec_t mk(input logic rst, input logic stl, input logic [31:0] instr,
                                input logic [31:0] pc4, input logic [31:0] rs, input logic [31:0] rt,
                                input logic chk, input logic [31:0] e_instr, input logic e_valid,
                                input logic e_pcsrc, input logic [31:0] e_badd,
                                input logic [31:0] e_pc4, input logic [15:0] e_cnt);
        vec_t v;
        v.rst = rst; v.stl = stl; v.instr = instr; v.pc4 = pc4; v.rs = rs; v.rt = rt;
        v.chk = chk; v.e_instr = e_instr; v.e_valid = e_valid; v.e_pcsrc = e_pcsrc;
        v.e_badd = e_badd; v.e_pc4 = e_pc4; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic cmp(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    initial begin
        vec_t e;
        logic [4:0]  exp_rs, exp_rt;
        logic [1:0]  exp_sat;
        //          rst  stl instr  pc4           rs  rt  chk e_instr e_v e_ps e_badd        e_pc4         cnt
        vecs.push_back(mk(1, 0, R_ADD, 32'h4,        0, 0, 0, 32'h0, 0, 0, 32'h0,        32'h0,        0));
        vecs.push_back(mk(1, 0, R_ADD, 32'h4,        0, 0, 1, 32'h0, 0, 0, 32'h0,        32'h0,        0));
        vecs.push_back(mk(0, 0, R_ADD, 32'h4,        0, 0, 1, 32'h0, 0, 0, 32'h0,        32'h0,        0));
        vecs.push_back(mk(0, 0, BEQ,   32'h14,       0, 0, 1, R_ADD, 1, 0, 32'h4,        32'h4,        0));
        vecs.push_back(mk(0, 0, R_ALT, 32'h18,       7, 7, 1, BEQ,   1, 1, 32'h20,       32'h14,       0));
        vecs.push_back(mk(0, 0, BEQ,   32'h14,       7, 8, 1, 32'h0, 0, 0, 32'h0,        32'h0,        1));
        vecs.push_back(mk(0, 0, R_ADD, 32'h18,       7, 8, 1, BEQ,   1, 0, 32'h20,       32'h14,       1));
        vecs.push_back(mk(0, 0, BNE,   32'h14,       0, 0, 1, R_ADD, 1, 0, 32'h18,       32'h18,       1));
        vecs.push_back(mk(0, 0, R_ADD, 32'h18,       1, 2, 1, BNE,   1, 1, 32'h0C,       32'h14,       1));
        vecs.push_back(mk(0, 0, BNE,   32'h4,        0, 0, 1, 32'h0, 0, 0, 32'h0,        32'h0,        2));
        vecs.push_back(mk(0, 0, JMP,   32'h40000008, 3, 4, 1, BNE,   1, 1, 32'hFFFFFFFC, 32'h4,        2));
        vecs.push_back(mk(0, 0, JMP,   32'h40000008, 0, 0, 1, 32'h0, 0, 0, 32'h0,        32'h0,        3));
        vecs.push_back(mk(0, 0, R_ADD, 32'h40000044, 5, 5, 1, JMP,   1, 1, 32'h40000040, 32'h40000008, 3));
        vecs.push_back(mk(0, 0, BEQ,   32'h14,       0, 0, 1, 32'h0, 0, 0, 32'h0,        32'h0,        4));
        vecs.push_back(mk(0, 1, R_ADD, 32'h18,       7, 7, 1, BEQ,   1, 0, 32'h20,       32'h14,       4));
        vecs.push_back(mk(0, 1, R_ALT, 32'h1C,       7, 7, 1, BEQ,   1, 0, 32'h20,       32'h14,       4));
        vecs.push_back(mk(0, 1, R_ADD, 32'h18,       7, 7, 1, BEQ,   1, 0, 32'h20,       32'h14,       4));
        vecs.push_back(mk(0, 0, R_ADD, 32'h18,       7, 7, 1, BEQ,   1, 1, 32'h20,       32'h14,       4));
        vecs.push_back(mk(0, 0, R_ADD, 32'h18,       0, 0, 1, 32'h0, 0, 0, 32'h0,        32'h0,        5));
        vecs.push_back(mk(0, 0, BEQ,   32'h14,       0, 0, 1, R_ADD, 1, 0, 32'h18,       32'h18,       5));
        vecs.push_back(mk(1, 0, R_ADD, 32'h4,        7, 7, 1, BEQ,   1, 1, 32'h20,       32'h14,       5));
        vecs.push_back(mk(0, 0, R_ADD, 32'h4,        7, 7, 1, 32'h0, 0, 0, 32'h0,        32'h0,        0));

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            reset             = vecs[i].rst;
            stall             = vecs[i].stl;
            instructionoutput = vecs[i].instr;
            PCPLUS4           = vecs[i].pc4;
            rs_data           = vecs[i].rs;
            rt_data           = vecs[i].rt;
            sb.push_back(vecs[i]);
            @(negedge clk);
            if (sb.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL scoreboard_empty cycle %0d: got 0 entries expected 1", i);
            end else begin
                e = sb.pop_front();
                if (e.chk) begin
                    exp_rs  = e.e_instr[25:21];
                    exp_rt  = e.e_instr[20:16];
                    exp_sat = (e.e_cnt > 16'd3) ? 2'd3 : e.e_cnt[1:0];
                    cmp("id_instr",     i, id_instr,     e.e_instr);
                    cmp("id_pcplus4",   i, id_pcplus4,   e.e_pc4);
                    cmp("id_valid",     i, {31'h0, id_valid}, {31'h0, e.e_valid});
                    cmp("PCSrc",        i, {31'h0, PCSrc},    {31'h0, e.e_pcsrc});
                    cmp("BranchAdd",    i, BranchAdd,    e.e_badd);
                    cmp("rs_addr",      i, {27'h0, rs_addr},  {27'h0, exp_rs});
                    cmp("rt_addr",      i, {27'h0, rt_addr},  {27'h0, exp_rt});
                    cmp("branch_count", i, {16'h0, branch_count}, {16'h0, e.e_cnt});
                    cmp("sat_count",    i, {30'h0, branch_count2}, {30'h0, exp_sat});
                    cmp("sat_PCSrc",    i, {31'h0, PCSrc2},   {31'h0, e.e_pcsrc});
                end
            end
        end

        // Hand-written: six back-to-back j redirects on the 2-bit counter saturate at 3
        @(posedge clk);
        #1;
        reset = 1'b0; stall = 1'b0; instructionoutput = JMP; PCPLUS4 = 32'h40000008;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        cmp("sat6_count", 0, {30'h0, branch_count2}, 32'd3);
        cmp("cnt6_count", 0, {16'h0, branch_count}, 32'd6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
